// File: rtl/expected_check_sequencer.sv
// expected_check_sequencer: admits N expected samples into an external delay line and checks DUT output against it
module expected_check_sequencer #(
    parameter int LATENCY    = 1,
    parameter int DATA_BITS  = 8,
    parameter int COUNT_BITS = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cke,
    input  logic                  start,
    input  logic                  abort,
    input  logic [COUNT_BITS-1:0] num_samples,
    input  logic [DATA_BITS-1:0]  exp_data,
    input  logic                  exp_valid,
    output logic [DATA_BITS-1:0]  dly_s_data,
    output logic                  dly_s_valid,
    input  logic [DATA_BITS-1:0]  dly_m_data,
    input  logic                  dly_m_valid,
    input  logic [DATA_BITS-1:0]  dut_data,
    input  logic                  dut_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [COUNT_BITS-1:0] err_count,
    output logic [COUNT_BITS-1:0] first_err_index,
    output logic [COUNT_BITS-1:0] checked_count
);
    localparam int DW = $clog2(TIMEOUT) + 1;

    if (TIMEOUT <= LATENCY) begin : g_bad_timeout
        $error("expected_check_sequencer: TIMEOUT must exceed LATENCY");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [COUNT_BITS-1:0] num_q;
    logic [COUNT_BITS-1:0] push_cnt;
    logic [DW-1:0]         drain_cnt;
    logic                  active;
    logic                  mismatch;
    logic                  overrun;
    logic                  unexpected;
    logic                  err_evt;
    logic                  chk_evt;
    logic [COUNT_BITS-1:0] chk_next;
    logic [COUNT_BITS-1:0] err_next;

    assign dly_s_data  = reset_n ? exp_data : '0;
    assign dly_s_valid = exp_valid && cke && state == RUN && push_cnt < num_q;
    assign busy        = state != IDLE;

    // Classify this cycle's compare and precompute the post-update counters
    always_comb begin
        active     = cke && state != IDLE;
        mismatch   = dly_m_valid && (!dut_valid || (dut_data !== dly_m_data));
        overrun    = dly_m_valid && checked_count == num_q;
        unexpected = dut_valid && !dly_m_valid;
        err_evt    = active && (mismatch || overrun || unexpected);
        chk_evt    = active && dly_m_valid && checked_count != num_q;
        chk_next   = checked_count + COUNT_BITS'(chk_evt);
        err_next   = (err_evt && err_count != '1) ? err_count + COUNT_BITS'(1) : err_count;
    end

    // Session state machine with registered result outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            num_q           <= '0;
            push_cnt        <= '0;
            drain_cnt       <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_err_index <= '0;
            checked_count   <= '0;
        end else if (abort) begin
            state <= IDLE;
            pass  <= 1'b0;
            done  <= 1'b0;
        end else if (!cke) begin
            done <= 1'b0;
        end else begin
            done          <= 1'b0;
            checked_count <= chk_next;
            err_count     <= err_next;
            if (err_evt && err_count == '0)
                first_err_index <= checked_count;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q           <= num_samples;
                        push_cnt        <= '0;
                        checked_count   <= '0;
                        err_count       <= '0;
                        first_err_index <= '0;
                        timeout         <= 1'b0;
                        pass            <= num_samples == '0;
                        done            <= num_samples == '0;
                        state           <= num_samples == '0 ? IDLE : RUN;
                    end
                end
                RUN: begin
                    if (dly_s_valid) begin
                        push_cnt <= push_cnt + COUNT_BITS'(1);
                        if (push_cnt + COUNT_BITS'(1) == num_q) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (chk_next == num_q) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        pass  <= err_next == '0;
                    end else if (drain_cnt == DW'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_expected_check_sequencer.sv
// tb_expected_check_sequencer: random and directed sessions against a fault-list reference model
module tb_expected_check_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_samples = '0;
    logic [7:0]  exp_data = 8'hA5;
    logic        exp_valid = 1'b1;
    logic [7:0]  dly_s_data;
    logic        dly_s_valid;
    logic [7:0]  dly_m_data;
    logic        dly_m_valid;
    logic [7:0]  dut_data;
    logic        dut_valid;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count, first_err_index, checked_count;

    logic [7:0]  dl_d [3];
    logic [2:0]  dl_v;
    logic [7:0]  fd [3];
    logic [2:0]  fv;
    int          pidx;
    logic [7:0]  fmask [16];
    bit          fdrop [16];
    logic [7:0]  vals [16];
    bit          line_on = 1'b1;
    bit          dut_on = 1'b1;

    int n_checks = 0, n_errs = 0;
    int n_done, n_push, viol, cyc_done, lastpush, lastchk;

    expected_check_sequencer #(.LATENCY(3), .DATA_BITS(8), .COUNT_BITS(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .cke(cke), .start(start), .abort(abort),
        .num_samples(num_samples), .exp_data(exp_data), .exp_valid(exp_valid),
        .dly_s_data(dly_s_data), .dly_s_valid(dly_s_valid),
        .dly_m_data(dly_m_data), .dly_m_valid(dly_m_valid),
        .dut_data(dut_data), .dut_valid(dut_valid),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_index(first_err_index), .checked_count(checked_count)
    );

    always #5 clk = ~clk;

    assign dly_m_valid = dl_v[2] & line_on;
    assign dly_m_data  = dl_d[2];
    assign dut_valid   = fv[2] & dut_on;
    assign dut_data    = fd[2];

    // Three-stage delay line plus a fake DUT echoing the same samples with injected faults
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_v <= '0;
            fv   <= '0;
            pidx <= 0;
            for (int i = 0; i < 3; i++) begin
                dl_d[i] <= '0;
                fd[i]   <= '0;
            end
        end else if (cke) begin
            dl_v  <= {dl_v[1:0], dly_s_valid};
            dl_d[0] <= dly_s_data;
            dl_d[1] <= dl_d[0];
            dl_d[2] <= dl_d[1];
            fv    <= {fv[1:0], dly_s_valid & !fdrop[pidx % 16]};
            fd[0] <= dly_s_data ^ fmask[pidx % 16];
            fd[1] <= fd[0];
            fd[2] <= fd[1];
            if (start && !busy) pidx <= 0;
            else if (dly_s_valid) pidx <= pidx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            fmask[i] = '0;
            fdrop[i] = 1'b0;
        end
    endtask

    // Reference: a sample is an error iff it was dropped or corrupted
    task automatic model(input int n, output int e, output int f);
        e = 0;
        f = 0;
        for (int i = 0; i < n; i++)
            if (fdrop[i] || fmask[i] != 0) begin
                if (e == 0) f = i;
                e++;
            end
    endtask

    task automatic check_results(input string tag, input int e_err, input int e_first,
                                 input int e_chk, input bit e_pass, input bit e_to);
        check({tag, ".err"}, 32'(err_count), 32'(e_err));
        check({tag, ".first"}, 32'(first_err_index), 32'(e_first));
        check({tag, ".checked"}, 32'(checked_count), 32'(e_chk));
        check({tag, ".pass"}, 32'(pass), 32'(e_pass));
        check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
        check({tag, ".ndone"}, 32'(n_done), 32'd1);
        check({tag, ".cke0_push"}, 32'(viol), 32'd0);
    endtask

    // ckm: 0 = cke always high, 1 = toggle every cycle, 2 = random
    task automatic session(input int n, input int ckm, input int gap, input int extra, input bit bstart);
        int sent;
        sent = 0;
        n_done = 0; n_push = 0; viol = 0;
        cyc_done = -1; lastpush = -1; lastchk = -1;
        @(negedge clk);
        start = 1'b1; num_samples = 16'(n); cke = 1'b1; exp_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                n_done++;
                if (cyc_done < 0) cyc_done = c;
            end
            if (n_done > 0 && c >= cyc_done + 3) break;
            cke = ckm == 0 ? 1'b1 : ckm == 1 ? (c % 2 == 0) : ($urandom_range(99) < 75);
            exp_valid = (sent < n + extra) && ($urandom_range(99) >= gap);
            exp_data = sent < n ? vals[sent] : 8'($urandom);
            if (bstart && c == 3) begin
                start = 1'b1;
                num_samples = 16'd9;
            end
            #1;
            if (dly_s_valid) begin
                n_push++;
                lastpush = c;
            end
            if (!cke && dly_s_valid) viol++;
            if (cke && dly_m_valid && busy) lastchk = c;
            if (cke && exp_valid) sent++;
        end
        start = 1'b0; exp_valid = 1'b0; cke = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, f;
        clear_faults();
        #3;
        check("rst.flags", {busy, done, pass, timeout, dly_s_valid}, 5'b0);
        check("rst.counts", {err_count, first_err_index}, 32'd0);
        check("rst.checked", 32'(checked_count), 32'd0);
        check("rst.s_data", 32'(dly_s_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; exp_valid = 1'b0;
        repeat (2) @(negedge clk);

        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        session(4, 0, 0, 0, 0);
        check_results("basic", 0, 0, 4, 1, 0);
        check("basic.pushes", 32'(n_push), 32'd4);
        check("basic.done_lat", 32'(cyc_done - lastchk), 32'd1);
        check("basic.busy_after", 32'(busy), 32'd0);

        fmask[1] = 8'h22 ^ 8'h2F; fmask[3] = 8'h44 ^ 8'h40;
        session(4, 0, 0, 0, 0);
        check_results("mismatch", 2, 1, 4, 0, 0);

        clear_faults();
        dut_on = 1'b0;
        session(2, 0, 0, 0, 0);
        check_results("missing", 2, 0, 2, 0, 0);

        line_on = 1'b0;
        session(2, 0, 0, 0, 0);
        check_results("tmo", 0, 0, 0, 0, 1);
        check("tmo.latency", 32'(cyc_done - lastpush), 32'd17);
        line_on = 1'b1; dut_on = 1'b1;
        repeat (5) @(negedge clk);

        session(4, 1, 0, 0, 0);
        check_results("cke_toggle", 0, 0, 4, 1, 0);
        check("cke_toggle.pushes", 32'(n_push), 32'd4);

        session(0, 0, 0, 0, 0);
        check_results("num0", 0, 0, 0, 1, 0);
        check("num0.done_lat", 32'(cyc_done), 32'd0);

        session(4, 0, 0, 6, 0);
        check_results("hold", 0, 0, 4, 1, 0);
        check("hold.pushes", 32'(n_push), 32'd4);

        session(4, 0, 0, 0, 1);
        check_results("busy_start", 0, 0, 4, 1, 0);
        check("busy_start.pushes", 32'(n_push), 32'd4);

        @(negedge clk);
        start = 1'b1; num_samples = 16'd4;
        @(negedge clk);
        start = 1'b0; exp_valid = 1'b1; exp_data = 8'h11;
        @(negedge clk);
        exp_data = 8'h22;
        @(negedge clk);
        exp_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort.ndone", 32'(n_done), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.pass", 32'(pass), 32'd0);
        check("abort.err", 32'(err_count), 32'd0);

        line_on = 1'b0; dut_on = 1'b0;
        start = 1'b1; num_samples = 16'd2;
        @(negedge clk);
        start = 1'b0; exp_valid = 1'b1; exp_data = 8'h5A;
        repeat (2) @(negedge clk);
        exp_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid.flags", {busy, done, pass, timeout, dly_s_valid}, 5'b0);
        check("rst_mid.counts", {err_count, first_err_index}, 32'd0);
        check("rst_mid.checked", 32'(checked_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; line_on = 1'b1; dut_on = 1'b1;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 25; s++) begin
            int n, r;
            n = $urandom_range(1, 8);
            clear_faults();
            for (int i = 0; i < 16; i++) begin
                vals[i] = 8'($urandom);
                r = $urandom_range(99);
                if (r < 15) fdrop[i] = 1'b1;
                else if (r < 30) fmask[i] = 8'($urandom_range(1, 255));
            end
            session(n, $urandom_range(2), $urandom_range(40), 0, 0);
            model(n, e, f);
            check_results($sformatf("rand%0d", s), e, f, n, e == 0, 0);
            check($sformatf("rand%0d.pushes", s), 32'(n_push), 32'(n));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
